// File: rtl/ras_ring_if.sv
// rtl/ras_ring_if.sv - request/response bundle between the frontend and the return-address stack
//
// Parameters: VLEN - return-address width.
// master modport (frontend): drives flush_i, push_i, push_addr_i, pop_i,
//   ckpt_save_i, ckpt_restore_i; observes the top/status/event outputs.
// slave modport (ras_ring): the reverse.
interface ras_ring_if #(
    parameter int VLEN = 32
);
    logic            flush_i;
    logic            push_i;
    logic [VLEN-1:0] push_addr_i;
    logic            pop_i;
    logic            ckpt_save_i;
    logic            ckpt_restore_i;
    logic            top_valid_o;
    logic [VLEN-1:0] top_addr_o;
    logic            full_o;
    logic            empty_o;
    logic            overflow_o;
    logic            underflow_o;

    modport master (
        output flush_i, push_i, push_addr_i, pop_i, ckpt_save_i, ckpt_restore_i,
        input  top_valid_o, top_addr_o, full_o, empty_o, overflow_o, underflow_o
    );

    modport slave (
        input  flush_i, push_i, push_addr_i, pop_i, ckpt_save_i, ckpt_restore_i,
        output top_valid_o, top_addr_o, full_o, empty_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/ras_ring.sv
// rtl/ras_ring.sv - circular return-address stack with overwrite-on-overflow
//
// Parameters: DEPTH (entries, >=1), VLEN (address width).
// Ports: clk_i - clock; rst_i - synchronous active-high reset;
//        bus   - ras_ring_if.slave (push/pop/flush/checkpoint requests,
//                top entry, full/empty status, overflow/underflow pulses).
// Optional feature: define RAS_CHECKPOINT_EN to build the {tos, cnt}
// speculation checkpoint driven by ckpt_save_i / ckpt_restore_i.
module ras_ring #(
    parameter int DEPTH = 2,
    parameter int VLEN  = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    ras_ring_if.slave   bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [VLEN-1:0] r_mem [DEPTH];
    logic [PW-1:0]   r_tos;
    logic [CW-1:0]   r_cnt;
    logic            r_overflow;
    logic            r_underflow;

    logic [PW-1:0]   w_tos_inc;
    logic [PW-1:0]   w_tos_dec;
    logic            w_full;
    logic            w_empty;

    // Compare-and-reset wrap so that non power-of-2 depths stay in range.
    assign w_tos_inc = (r_tos == PW'(DEPTH - 1)) ? '0 : r_tos + PW'(1);
    assign w_tos_dec = (r_tos == '0) ? PW'(DEPTH - 1) : r_tos - PW'(1);
    assign w_full    = (r_cnt == CW'(DEPTH));
    assign w_empty   = (r_cnt == '0);

`ifdef RAS_CHECKPOINT_EN
    logic [PW-1:0] r_ckpt_tos;
    logic [CW-1:0] r_ckpt_cnt;
`else
    logic w_unused_ckpt;
    assign w_unused_ckpt = bus.ckpt_save_i ^ bus.ckpt_restore_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_tos       <= '0;
            r_cnt       <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
`ifdef RAS_CHECKPOINT_EN
            r_ckpt_tos  <= '0;
            r_ckpt_cnt  <= '0;
`endif
        end else begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            if (bus.flush_i) begin
                r_tos <= '0;
                r_cnt <= '0;
`ifdef RAS_CHECKPOINT_EN
                r_ckpt_tos <= '0;
                r_ckpt_cnt <= '0;
            end else if (bus.ckpt_restore_i) begin
                // Restore also drops any push/pop, and a concurrent save.
                r_tos <= r_ckpt_tos;
                r_cnt <= r_ckpt_cnt;
`endif
            end else begin
`ifdef RAS_CHECKPOINT_EN
                if (bus.ckpt_save_i) begin
                    r_ckpt_tos <= r_tos;
                    r_ckpt_cnt <= r_cnt;
                end
`endif
                if (bus.push_i && bus.pop_i) begin
                    if (!w_empty) begin
                        // Return then call: replace the top in place.
                        r_mem[r_tos] <= bus.push_addr_i;
                    end else begin
                        r_mem[w_tos_inc] <= bus.push_addr_i;
                        r_tos            <= w_tos_inc;
                        r_cnt            <= CW'(1);
                        r_underflow      <= 1'b1;
                    end
                end else if (bus.push_i) begin
                    r_mem[w_tos_inc] <= bus.push_addr_i;
                    r_tos            <= w_tos_inc;
                    if (w_full) r_overflow <= 1'b1;
                    else        r_cnt      <= r_cnt + CW'(1);
                end else if (bus.pop_i) begin
                    if (!w_empty) begin
                        r_tos <= w_tos_dec;
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        r_underflow <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.top_valid_o = !w_empty;
    assign bus.top_addr_o  = w_empty ? '0 : r_mem[r_tos];
    assign bus.full_o      = w_full;
    assign bus.empty_o     = w_empty;
    assign bus.overflow_o  = r_overflow;
    assign bus.underflow_o = r_underflow;
endmodule
